multiplicador_booth: RTL and testbench
======================================

// Module: multiplicador_booth
// PURPOSE
// Sequential signed radix-2 Booth multiplier for two WIDTH-bit two's-complement operands.
// Produces a registered 2*WIDTH-bit product. This is the stage directly upstream of the
//   7-segment display driver, whose bin[15:0] input consumes the product (WIDTH=8).
// Operands are captured on a start pulse. One Booth step runs per clock.
// A one-cycle listo pulse flags each new result. The product holds until the next result.
// PARAMETERS
// WIDTH  8  operand width in bits; product width is 2*WIDTH
// PORTS
// clk            in   1          system clock (100 MHz), rising-edge
// reset          in   1          asynchronous, active-high; clears all state
// inicio         in   1          start request, sampled only in IDLE
// multiplicando  in   WIDTH      signed operand M, captured when start is accepted
// multiplicador  in   WIDTH      signed operand Q, captured when start is accepted
// producto       out  2*WIDTH    signed product M*Q, registered, held between operations
// listo          out  1          1-cycle pulse: producto has just been updated
// ocupado        out  1          1 while state != IDLE (decoded from the state register)
// BEHAVIOUR
// - Reset (async, active-high): state=IDLE, producto=0, listo=0, ocupado=0.
//   Acc, Q, Q_-1 and contador are cleared. An operation in progress is aborted.
// - Datapath registers: M[WIDTH-1:0], Acc[WIDTH:0] (one guard bit), Q[WIDTH-1:0],
//   Q_-1 (1 bit), contador[$clog2(WIDTH+1)-1:0].
// - FSM states: IDLE, CALC, FIN.
// - IDLE:
//   - On an edge with inicio=1: M<=multiplicando; Q<=multiplicador; Acc<=0; Q_-1<=0;
//     contador<=WIDTH; next state CALC.
//   - On an edge with inicio=0: stay in IDLE.
// - CALC, one step per edge:
//   - {Q[0],Q_-1}=01: Acc_t = Acc + sext(M).
//   - {Q[0],Q_-1}=10: Acc_t = Acc - sext(M).
//   - 00 or 11: Acc_t = Acc.
//   - Then arithmetic right shift of {Acc_t,Q,Q_-1}; the MSB of Acc_t is replicated.
//   - contador decrements on each step.
//   - After the step taken with contador==1, next state is FIN.
//   - Exactly WIDTH steps are performed.
// - FIN, one edge: producto <= {Acc[WIDTH-1:0],Q}; listo<=1; next state IDLE.
// - listo is a registered signal. It is high for exactly the one cycle after the FIN edge,
//   and returns to 0 on the following edge.
// - Latency: start accepted at edge k -> producto valid and listo=1 after edge k+WIDTH+1.
//   For WIDTH=8 that is 9 edges.
// - Arithmetic: the guard bit makes -(-2^(WIDTH-1)) exact, so every operand pair is correct.
//   The product is exact in 2*WIDTH bits, so no overflow is possible.
// - inicio while in CALC or FIN: ignored. No queuing; operands are not re-sampled.
// - inicio high in the cycle where listo=1: the state is IDLE, so the start is accepted.
//   Back-to-back operations therefore have a period of WIDTH+2 edges.
// - inicio held continuously high: the block restarts every WIDTH+2 edges with freshly
//   sampled operands.
// - Operand inputs may change freely while ocupado=1 without affecting the result.
// - Reset asserted mid-CALC: outputs drop to reset values immediately, without waiting for
//   a clock edge. After reset is released, the first inicio starts a clean operation.
// TESTING
// 1. Reset; inicio 1 cycle with 7 x 3 -> ocupado=1 for 9 cycles; listo pulse exactly
//    9 edges after the start edge; producto=16'h0015.
// 2. -5 x 7 -> 16'hFFDD.  127 x -128 -> 16'hC080.  -128 x -128 -> 16'h4000.
//    0 x -1 -> 16'h0000.
// 3. Start 10 x 10, then pulse inicio with 3 x 3 during CALC -> single listo;
//    producto=16'h0064; no second result.
// 4. inicio held high with operands changing each cycle -> listo every 10 edges.
//    Each product matches the operands present at its accepting edge.
// 5. Reset asserted 4 cycles into CALC (after a prior result 16'h0015) -> producto=0,
//    listo=0 and ocupado=0 immediately. Then 2 x -3 -> 16'hFFFA.
// 6. Random sweep of 1000 operand pairs vs. a signed reference model:
//    all products match; listo is never high for 2 consecutive cycles.

Source files
------------

// File: rtl/multiplicador_booth.sv
// Sequential signed radix-2 Booth multiplier, one step per clock.
// Registered product and a one-cycle listo pulse per result.
module multiplicador_booth #(
  parameter int WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 inicio,
  input  logic [WIDTH-1:0]     multiplicando,
  input  logic [WIDTH-1:0]     multiplicador,
  output logic [2*WIDTH-1:0]   producto,
  output logic                 listo,
  output logic                 ocupado
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    FIN
  } state_t;

  state_t               state_q;
  logic [WIDTH-1:0]     m_q;
  logic [WIDTH-1:0]     q_q;
  logic [WIDTH:0]       acc_q;
  logic                 qm1_q;
  logic [CW-1:0]        cnt_q;
  logic [2*WIDTH-1:0]   prod_q;
  logic                 listo_q;

  logic [WIDTH:0]       m_ext;
  logic [WIDTH:0]       acc_d;

  // Guard bit on Acc keeps -(-2^(WIDTH-1)) representable.
  always_comb begin
    m_ext = {m_q[WIDTH-1], m_q};
    acc_d = acc_q;
    unique case ({q_q[0], qm1_q})
      2'b01:   acc_d = acc_q + m_ext;
      2'b10:   acc_d = acc_q - m_ext;
      default: acc_d = acc_q;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      m_q     <= '0;
      q_q     <= '0;
      acc_q   <= '0;
      qm1_q   <= 1'b0;
      cnt_q   <= '0;
      prod_q  <= '0;
      listo_q <= 1'b0;
    end else begin
      listo_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (inicio) begin
            m_q     <= multiplicando;
            q_q     <= multiplicador;
            acc_q   <= '0;
            qm1_q   <= 1'b0;
            cnt_q   <= CW'(WIDTH);
            state_q <= CALC;
          end
        end
        CALC: begin
          acc_q <= {acc_d[WIDTH], acc_d[WIDTH:1]};
          q_q   <= {acc_d[0], q_q[WIDTH-1:1]};
          qm1_q <= q_q[0];
          cnt_q <= cnt_q - 1'b1;
          if (cnt_q == CW'(1)) begin
            state_q <= FIN;
          end
        end
        FIN: begin
          prod_q  <= {acc_q[WIDTH-1:0], q_q};
          listo_q <= 1'b1;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign producto = prod_q;
  assign listo    = listo_q;
  assign ocupado  = (state_q != IDLE);

endmodule

// File: tb/tb_multiplicador_booth.sv
// Bench for multiplicador_booth: cycle model of start/latency plus
// signed products, with literal spot checks.
module tb_multiplicador_booth;

  logic        clk = 1'b0;
  logic        reset;
  logic        inicio;
  logic [7:0]  multiplicando;
  logic [7:0]  multiplicador;
  logic [15:0] producto;
  logic        listo;
  logic        ocupado;

  int tests = 0;
  int fails = 0;

  multiplicador_booth #(.WIDTH(8)) dut (
    .clk           (clk),
    .reset         (reset),
    .inicio        (inicio),
    .multiplicando (multiplicando),
    .multiplicador (multiplicador),
    .producto      (producto),
    .listo         (listo),
    .ocupado       (ocupado)
  );

  always #5 clk = ~clk;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Model: an accepted start yields a*b exactly 9 edges later.
  int                 m_busy;
  logic signed [15:0] m_pend;
  logic signed [15:0] m_prod;
  logic               m_listo;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_busy  <= 0;
      m_pend  <= '0;
      m_prod  <= '0;
      m_listo <= 1'b0;
    end else begin
      m_listo <= 1'b0;
      if (m_busy == 0) begin
        if (inicio) begin
          m_busy <= 9;
          m_pend <= $signed(multiplicando) * $signed(multiplicador);
        end
      end else begin
        m_busy <= m_busy - 1;
        if (m_busy == 1) begin
          m_prod  <= m_pend;
          m_listo <= 1'b1;
        end
      end
    end
  end

  logic prev_listo = 1'b0;

  always @(posedge clk) begin
    #2;
    chk("cmp_producto", {16'h0, producto}, {16'h0, m_prod});
    chk("cmp_listo", {31'h0, listo}, {31'h0, m_listo});
    chk("cmp_ocupado", {31'h0, ocupado}, {31'h0, (m_busy != 0)});
    if (listo && prev_listo) begin
      chk("listo_twice", 32'd1, 32'd0);
    end
    prev_listo = listo;
  end

  task automatic start(input logic [7:0] a, input logic [7:0] b);
    @(negedge clk);
    multiplicando = a;
    multiplicador = b;
    inicio = 1'b1;
    @(negedge clk);
    inicio = 1'b0;
    multiplicando = 8'($urandom);
    multiplicador = 8'($urandom);
  endtask

  task automatic wait_listo(output int n);
    n = 0;
    while (n < 30) begin
      @(posedge clk);
      #2;
      n++;
      if (listo) break;
    end
    if (!listo) chk("timeout", 32'd1, 32'd0);
  endtask

  task automatic run_op(input logic [7:0] a, input logic [7:0] b,
                        input logic [15:0] exp);
    int n;
    start(a, b);
    wait_listo(n);
    chk("latency", n, 32'd9);
    chk("product", {16'h0, producto}, {16'h0, exp});
  endtask

  initial begin
    int n;
    int occ;
    int cnt;
    int idx[$];
    logic signed [7:0]  ra;
    logic signed [7:0]  rb;
    logic signed [15:0] rp;

    reset = 1'b1;
    inicio = 1'b0;
    multiplicando = '0;
    multiplicador = '0;
    repeat (3) @(negedge clk);
    chk("rst_producto", {16'h0, producto}, 32'h0);
    chk("rst_listo", {31'h0, listo}, 32'h0);
    chk("rst_ocupado", {31'h0, ocupado}, 32'h0);
    reset = 1'b0;

    // 7 x 3 with ocupado and latency count
    @(negedge clk);
    multiplicando = 8'd7;
    multiplicador = 8'd3;
    inicio = 1'b1;
    @(negedge clk);
    inicio = 1'b0;
    occ = ocupado ? 1 : 0;
    n = 0;
    while (n < 30) begin
      @(posedge clk);
      #2;
      n++;
      if (ocupado) occ++;
      if (listo) break;
    end
    chk("t1_latency", n, 32'd9);
    chk("t1_ocupado_cycles", occ, 32'd9);
    chk("t1_product", {16'h0, producto}, 32'h0015);

    run_op(8'hFB, 8'd7, 16'hFFDD);
    run_op(8'd127, 8'h80, 16'hC080);
    run_op(8'h80, 8'h80, 16'h4000);
    run_op(8'd0, 8'hFF, 16'h0000);

    // inicio during CALC is ignored
    start(8'd10, 8'd10);
    repeat (2) @(negedge clk);
    multiplicando = 8'd3;
    multiplicador = 8'd3;
    inicio = 1'b1;
    @(negedge clk);
    inicio = 1'b0;
    wait_listo(n);
    chk("t3_product", {16'h0, producto}, 32'h0064);
    cnt = 0;
    repeat (20) begin
      @(posedge clk);
      #2;
      if (listo) cnt++;
    end
    chk("t3_no_second", cnt, 32'd0);

    // inicio held high: a result every 10 edges
    @(negedge clk);
    multiplicando = 8'($urandom);
    multiplicador = 8'($urandom);
    inicio = 1'b1;
    for (int i = 0; i < 45; i++) begin
      @(posedge clk);
      #2;
      if (listo) idx.push_back(i);
      @(negedge clk);
      multiplicando = 8'($urandom);
      multiplicador = 8'($urandom);
    end
    inicio = 1'b0;
    chk("t4_count", idx.size(), 32'd4);
    if (idx.size() == 4) begin
      chk("t4_first", idx[0], 32'd9);
      for (int i = 1; i < 4; i++) chk("t4_period", idx[i] - idx[i-1], 32'd10);
    end
    repeat (12) @(negedge clk);

    // reset mid-CALC
    run_op(8'd7, 8'd3, 16'h0015);
    start(8'd5, 8'd5);
    repeat (4) @(posedge clk);
    #2;
    chk("t5_busy", {31'h0, ocupado}, 32'h1);
    #1;
    reset = 1'b1;
    #1;
    chk("t5_producto", {16'h0, producto}, 32'h0);
    chk("t5_listo", {31'h0, listo}, 32'h0);
    chk("t5_ocupado", {31'h0, ocupado}, 32'h0);
    @(negedge clk);
    reset = 1'b0;
    run_op(8'd2, 8'hFD, 16'hFFFA);

    // random sweep
    for (int i = 0; i < 1000; i++) begin
      ra = 8'($urandom);
      rb = 8'($urandom);
      rp = ra * rb;
      run_op(ra, rb, rp);
    end

    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
